instruction_prefetch: RTL and testbench
=======================================

# instruction_prefetch

Byte-wide instruction prefetch queue sitting directly upstream of the decoder. It drives the memory read port from its own fetch PC and buffers returned opcode/operand bytes in a small FIFO. It presents the head byte and that byte's address to the decoder under a valid/pop handshake. Flushes on taken branches, jumps and interrupts, and refetches from a supplied address.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, ≥2
- ADDR_W, 16: address width
- RESET_PC, 16'h0000: fetch address after reset

Ports:
- clk_2  in  1  sole clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard queue and in-flight byte, redirect fetch
- flush_addr  in  ADDR_W  new fetch address, sampled when flush=1
- mem_rd  out  1  read request this cycle
- mem_addr  out  ADDR_W  read address; meaningful when mem_rd=1
- mem_data  in  8  read data, valid exactly one cycle after mem_rd
- instruction  out  8  head byte of queue
- instr_pc  out  ADDR_W  address of head byte
- q_valid  out  1  queue non-empty
- pop  in  1  decoder consumes head byte this cycle
- level  out  $clog2(DEPTH+1)  bytes currently queued

## Operation
- Registers: fetch_pc, inflight flag, inflight_pc, FIFO (byte + pc per entry), rd/wr pointers, count.
- Issue: mem_rd = !rst && !flush && (count + inflight < DEPTH); mem_addr = fetch_pc. On issue: fetch_pc += 1 (wraps FFFF→0000 at ADDR_W), inflight ← 1, inflight_pc ← fetch_pc; else inflight ← 0.
- Return: if inflight and not flush, push {mem_data, inflight_pc} at wr pointer.
- Pop: if pop && q_valid, advance rd pointer. Pop with q_valid=0 is ignored.
- Simultaneous push+pop: count unchanged, both pointers advance. Issue rule excludes same-cycle pop, so push always has room; overflow is impossible.
- Flush (priority over push, pop, issue): count ← 0, pointers ← 0, inflight ← 0, fetch_pc ← flush_addr; in-flight byte dropped; mem_rd=0 in flush cycle. flush held multiple cycles: each cycle re-redirects; last flush_addr wins.
- Reset: as flush with fetch_pc ← RESET_PC. Reset mid-operation discards everything identically.
- Derived FSM states: FILL (count+inflight < DEPTH, issuing every cycle), STALL (full incl. in-flight, mem_rd=0), REDIRECT (flush/rst cycle). REDIRECT→FILL next cycle unconditionally; FILL↔STALL on occupancy.
- Reset values: mem_rd=0, mem_addr=RESET_PC, q_valid=0, level=0, instr_pc=don't-care but driven (0), instruction=0.

## Timing
- Memory latency fixed at 1: request in cycle N, data sampled cycle N+1, q_valid visible cycle N+2.
- After flush in cycle F: first mem_rd at flush_addr in F+1, data F+2, q_valid=1 with instr_pc=flush_addr in F+3.
- After rst high in cycle R and low in R+1: mem_rd=1 at RESET_PC in R+1.
- Throughput: 1 byte/cycle sustained with pop every cycle once primed.
- instruction/instr_pc/q_valid are registered-state outputs, stable for the whole cycle; pop takes effect at next edge.

## Structure
- Shared package mosby_pkg: ADDR_W, RESET_PC constant, pc type (logic [ADDR_W-1:0]).
- One sub-module: prefetch_fifo (DEPTH entries of {byte, pc}, push/pop/clear, count, registered head). Issue logic, fetch_pc and inflight tracking stay in instruction_prefetch.

## Test plan
- Reset then run, memory returns mem[a]=a[7:0], no pops → mem_rd at 0000..0003 in cycles 1–4, then mem_rd=0; level=4; head 8'h00 pc 0000.
- Continuous pop from cycle 3 → consecutive instruction bytes 00,01,02…, instr_pc increments by 1 every cycle, no gaps, level never exceeds DEPTH.
- Flush at cycle F with flush_addr=16'h1234 while full and one in flight → level=0 at F+1, mem_rd at 1234 in F+1, q_valid with pc 1234 at F+3; no pre-flush byte ever appears.
- fetch_pc reaches FFFF (flush to FFFE) → bytes at FFFE, FFFF, then 0000 in order.
- pop while q_valid=0 after reset → level stays 0, no pointer movement; push+pop same cycle at level=DEPTH-1 → level unchanged.
- rst asserted mid-stream with level=3 → next cycle level=0, q_valid=0, mem_rd at RESET_PC after rst deasserts.

Source files
------------

// File: rtl/instruction_prefetch_pkg.sv
// Shared definitions for the instruction prefetch slice: address width,
// reset fetch address, PC type and the prefetch state encoding.
package mosby_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef logic [ADDR_W-1:0] pc_t;

    typedef enum logic [1:0] {
        PF_REDIRECT,
        PF_FILL,
        PF_STALL
    } pf_state_e;

endpackage

// File: rtl/instruction_prefetch_if.sv
// Prefetch queue bus: redirect control, memory read port and decoder handshake.
// master = prefetch queue side, slave = core/memory/decoder side.
interface instruction_prefetch_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 16
);
    localparam int unsigned LEVEL_W = $clog2(DEPTH + 1);

    logic              flush;
    logic [ADDR_W-1:0] flush_addr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic [7:0]        instruction;
    logic [ADDR_W-1:0] instr_pc;
    logic              q_valid;
    logic              pop;
    logic [LEVEL_W-1:0] level;

    modport master (
        input  flush, flush_addr, mem_data, pop,
        output mem_rd, mem_addr, instruction, instr_pc, q_valid, level
    );

    modport slave (
        output flush, flush_addr, mem_data, pop,
        input  mem_rd, mem_addr, instruction, instr_pc, q_valid, level
    );

endinterface

// File: rtl/instruction_prefetch_fifo.sv
// Circular queue of {opcode byte, fetch address} entries with synchronous
// clear; head entry is read straight from the storage registers.
module prefetch_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic                         push,
    input  logic [7:0]                   push_byte,
    input  logic [ADDR_W-1:0]            push_pc,
    input  logic                         pop,
    output logic [7:0]                   head_byte,
    output logic [ADDR_W-1:0]            head_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [7:0]        byte_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              do_pop;

    assign do_pop = pop && (cnt != '0);

    always_ff @(posedge clk) begin
        if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                byte_mem[PTR_W'(i)] <= '0;
                pc_mem[PTR_W'(i)]   <= '0;
            end
        end else begin
            if (push) begin
                byte_mem[wr_ptr] <= push_byte;
                pc_mem[wr_ptr]   <= push_pc;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_byte = byte_mem[rd_ptr];
    assign head_pc   = pc_mem[rd_ptr];
    assign count     = cnt;

endmodule

// File: rtl/instruction_prefetch.sv
// Byte-wide instruction prefetch queue: issues one memory read per cycle while
// queue plus in-flight byte has room, and redirects on flush or reset.
module instruction_prefetch #(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = mosby_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = mosby_pkg::RESET_PC
) (
    input logic                    clk_2,
    input logic                    rst,
    instruction_prefetch_if.master bus
);
    import mosby_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    pf_state_e         state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              redirect;
    logic              issue;
    logic              push;
    logic              pop_ok;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W:0]    occ_next;

    assign redirect = rst || bus.flush;
    // STALL is registered from next-cycle occupancy (queue + in-flight), so
    // issuing only outside STALL is equivalent to count+inflight < DEPTH.
    assign issue    = !redirect && (state != PF_STALL);
    assign push     = inflight && !redirect;
    assign pop_ok   = bus.pop && (count != '0);

    always_comb begin
        count_next = count;
        if (push && !pop_ok) begin
            count_next = count + CNT_W'(1);
        end else if (!push && pop_ok) begin
            count_next = count - CNT_W'(1);
        end
        occ_next = {1'b0, count_next} + (CNT_W + 1)'(issue);
    end

    always_ff @(posedge clk_2) begin
        if (redirect) begin
            state    <= PF_REDIRECT;
            inflight <= 1'b0;
            fetch_pc <= rst ? RESET_PC : bus.flush_addr;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + ADDR_W'(1);
                inflight_pc <= fetch_pc;
            end
            state <= (occ_next < (CNT_W + 1)'(DEPTH)) ? PF_FILL : PF_STALL;
        end
    end

    prefetch_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk_2),
        .clear     (redirect),
        .push      (push),
        .push_byte (bus.mem_data),
        .push_pc   (inflight_pc),
        .pop       (pop_ok),
        .head_byte (bus.instruction),
        .head_pc   (bus.instr_pc),
        .count     (count)
    );

    assign bus.mem_rd   = issue;
    assign bus.mem_addr = fetch_pc;
    assign bus.q_valid  = (count != '0);
    assign bus.level    = count;

endmodule

// File: tb/tb_instruction_prefetch.sv
// Self-checking bench for instruction_prefetch: directed scenarios with literal
// expectations, then randomized flush/reset/pop traffic against a queue model.
module tb_instruction_prefetch;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 16;
    localparam logic [AW-1:0] RST_PC = 16'h0000;

    typedef struct {
        logic [7:0]    b;
        logic [AW-1:0] pc;
    } ent_t;

    logic clk_2 = 1'b0;
    logic rst;
    always #5 clk_2 = ~clk_2;

    instruction_prefetch_if #(.DEPTH(DEPTH), .ADDR_W(AW)) bus ();

    instruction_prefetch #(
        .DEPTH    (DEPTH),
        .ADDR_W   (AW),
        .RESET_PC (RST_PC)
    ) dut (
        .clk_2 (clk_2),
        .rst   (rst),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state: what the prefetcher must hold, described as a plain queue.
    ent_t          q[$];
    bit            m_infl;
    logic [AW-1:0] m_infl_pc;
    logic [AW-1:0] m_fetch;
    bit            pend;
    logic [AW-1:0] pend_addr;

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare every output, advance the model.
    task automatic step(input bit r, input bit f, input logic [AW-1:0] fa, input bit p);
        bit   exp_rd;
        ent_t e;
        @(negedge clk_2);
        bus.mem_data   = pend ? mem_byte(pend_addr) : 8'($urandom);
        rst            = r;
        bus.flush      = f;
        bus.flush_addr = fa;
        bus.pop        = p;
        #1;
        exp_rd = !r && !f && ((q.size() + int'(m_infl)) < DEPTH);
        chk("mem_rd", 32'(bus.mem_rd), 32'(exp_rd));
        if (exp_rd) chk("mem_addr", 32'(bus.mem_addr), 32'(m_fetch));
        chk("q_valid", 32'(bus.q_valid), 32'(q.size() != 0));
        chk("level", 32'(bus.level), 32'(q.size()));
        if (q.size() != 0) begin
            chk("instr_pc", 32'(bus.instr_pc), 32'(q[0].pc));
            chk("instruction", 32'(bus.instruction), 32'(q[0].b));
            if (p) chk("stream_byte", 32'(bus.instruction), 32'(mem_byte(bus.instr_pc)));
        end
        pend      = exp_rd;
        pend_addr = m_fetch;
        if (r || f) begin
            q.delete();
            m_infl  = 1'b0;
            m_fetch = r ? RST_PC : fa;
        end else begin
            if (p && q.size() != 0) void'(q.pop_front());
            if (m_infl) begin
                e.b  = bus.mem_data;
                e.pc = m_infl_pc;
                q.push_back(e);
            end
            if (q.size() > DEPTH) chk("overflow", 32'(q.size()), 32'(DEPTH));
            m_infl = exp_rd;
            if (exp_rd) begin
                m_infl_pc = m_fetch;
                m_fetch   = m_fetch + 16'd1;
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.flush      = 1'b0;
        bus.flush_addr = '0;
        bus.pop        = 1'b0;
        bus.mem_data   = '0;
        m_infl         = 1'b0;
        m_infl_pc      = '0;
        m_fetch        = RST_PC;
        pend           = 1'b0;
        pend_addr      = '0;

        // Reset, then fill with no pops.
        step(1, 0, 0, 0);
        chk("lit_rst_instr", 32'(bus.instruction), 32'h0);
        chk("lit_rst_level", 32'(bus.level), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 0);
            chk("lit_fill_rd", 32'(bus.mem_rd), 32'h1);
            chk("lit_fill_addr", 32'(bus.mem_addr), 32'(i - 1));
        end
        step(0, 0, 0, 0);
        chk("lit_stall_rd", 32'(bus.mem_rd), 32'h0);
        step(0, 0, 0, 0);
        chk("lit_full_level", 32'(bus.level), 32'h4);
        chk("lit_full_head", 32'(bus.instruction), 32'h00);
        chk("lit_full_pc", 32'(bus.instr_pc), 32'h0000);

        // Continuous pop: gapless consecutive bytes.
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 1);
            chk("lit_pop_valid", 32'(bus.q_valid), 32'h1);
            chk("lit_pop_pc", 32'(bus.instr_pc), 32'(k));
            chk("lit_pop_byte", 32'(bus.instruction), 32'(k));
        end

        // Refill, pop once, let a byte go in flight, then flush to 1234.
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("lit_preflush_level", 32'(bus.level), 32'h3);
        step(0, 1, 16'h1234, 0);
        chk("lit_flush_rd", 32'(bus.mem_rd), 32'h0);
        step(0, 0, 0, 0);
        chk("lit_f1_level", 32'(bus.level), 32'h0);
        chk("lit_f1_rd", 32'(bus.mem_rd), 32'h1);
        chk("lit_f1_addr", 32'(bus.mem_addr), 32'h1234);
        step(0, 0, 0, 0);
        chk("lit_f2_valid", 32'(bus.q_valid), 32'h0);
        step(0, 0, 0, 0);
        chk("lit_f3_valid", 32'(bus.q_valid), 32'h1);
        chk("lit_f3_pc", 32'(bus.instr_pc), 32'h1234);
        chk("lit_f3_byte", 32'(bus.instruction), 32'h26);

        // Address wrap FFFE -> FFFF -> 0000.
        step(0, 1, 16'hFFFE, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("lit_wrap0", 32'(bus.instr_pc), 32'hFFFE);
        step(0, 0, 0, 1);
        chk("lit_wrap1", 32'(bus.instr_pc), 32'hFFFF);
        step(0, 0, 0, 1);
        chk("lit_wrap2", 32'(bus.instr_pc), 32'h0000);

        // Pop on empty queue after reset is ignored.
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("lit_emptypop_level", 32'(bus.level), 32'h0);
        step(0, 0, 0, 0);
        chk("lit_emptypop_pc", 32'(bus.instr_pc), 32'h0000);
        chk("lit_emptypop_lvl1", 32'(bus.level), 32'h1);
        step(0, 0, 0, 0);
        // Level DEPTH-1 with push and pop together.
        step(0, 0, 0, 1);
        chk("lit_pp_before", 32'(bus.level), 32'h3);
        step(0, 0, 0, 0);
        chk("lit_pp_after", 32'(bus.level), 32'h3);

        // Reset mid-stream at level 3.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("lit_rst_mid_level", 32'(bus.level), 32'h0);
        chk("lit_rst_mid_valid", 32'(bus.q_valid), 32'h0);
        chk("lit_rst_mid_rd", 32'(bus.mem_rd), 32'h1);
        chk("lit_rst_mid_addr", 32'(bus.mem_addr), 32'(RST_PC));

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            bit            r, f, p;
            logic [AW-1:0] fa;
            r  = ($urandom_range(0, 199) == 0);
            f  = ($urandom_range(0, 39) == 0) || (f && $urandom_range(0, 1) == 0);
            fa = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                             : 16'($urandom);
            p  = ($urandom_range(0, 3) != 0);
            step(r, f, fa, p);
        end
        step(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
